// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester front end for a 16-bit SRAM controller.
// Each 32-bit request is split into a low and a high halfword access; write
// halves with no strobes set are skipped. Arbitration is round-robin
// (FAIR=1) or fixed priority to m0 (FAIR=0).
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   mX_valid/addr/wdata/wstrb   requester X command (wstrb 0000 = read)
//   mX_rdata, mX_ready    requester X read data and completion pulse
//   s_valid/we/addr/wdata/ben   downstream halfword request
//   s_rdata, s_ready      downstream read data and completion
//   busy, owner           not-IDLE flag, current/last granted requester
module sram_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic        s_we,
  output logic [17:0] s_addr,
  output logic [15:0] s_wdata,
  output logic [1:0]  s_ben,
  input  logic [15:0] s_rdata,
  input  logic        s_ready,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      r_state;
  logic [16:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_last;
  logic        r_owner;
  logic        r_m0_ready, r_m1_ready;
  logic        r_s_valid, r_s_we;
  logic [17:0] r_s_addr;
  logic [15:0] r_s_wdata;
  logic [1:0]  r_s_ben;

  // Grant selection: contention goes to the requester not served last when
  // fair, otherwise to m0; a lone requester always wins.
  logic        w_req, w_gnt, w_rd, w_lo;
  logic [31:0] w_addr, w_wdata;
  logic [3:0]  w_wstrb;
  logic        r_rd, r_need_hi;

  assign w_req   = m0_valid | m1_valid;
  assign w_gnt   = (m0_valid && m1_valid) ? (FAIR ? ~r_last : 1'b0) : m1_valid;
  assign w_addr  = w_gnt ? m1_addr  : m0_addr;
  assign w_wdata = w_gnt ? m1_wdata : m0_wdata;
  assign w_wstrb = w_gnt ? m1_wstrb : m0_wstrb;
  assign w_rd    = (w_wstrb == 4'b0000);
  // A write with only upper strobes starts directly in HI.
  assign w_lo    = w_rd | (|w_wstrb[1:0]);

  assign r_rd      = (r_wstrb == 4'b0000);
  assign r_need_hi = r_rd | (|r_wstrb[3:2]);

  // Address bits outside [18:2] are intentionally ignored.
  logic w_unused_ok;
  assign w_unused_ok = ^{m0_addr[31:19], m0_addr[1:0], m1_addr[31:19], m1_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_last     <= 1'b1;   // m0 wins the first contention
      r_owner    <= 1'b0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_s_valid  <= 1'b0;
      r_s_we     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_s_ben    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_owner   <= w_gnt;
            r_last    <= w_gnt;
            r_addr    <= w_addr[18:2];
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_s_valid <= 1'b1;
            r_s_we    <= ~w_rd;
            if (w_lo) begin
              r_state   <= LO;
              r_s_addr  <= {w_addr[18:2], 1'b0};
              r_s_wdata <= w_wdata[15:0];
              r_s_ben   <= w_rd ? 2'b11 : w_wstrb[1:0];
            end else begin
              r_state   <= HI;
              r_s_addr  <= {w_addr[18:2], 1'b1};
              r_s_wdata <= w_wdata[31:16];
              r_s_ben   <= w_wstrb[3:2];
            end
          end
        end
        LO: begin
          if (s_ready) begin
            r_rdata[15:0] <= s_rdata;
            if (r_need_hi) begin
              // s_valid stays high; only the fields move to the upper half.
              r_state   <= HI;
              r_s_addr  <= {r_addr, 1'b1};
              r_s_wdata <= r_wdata[31:16];
              r_s_ben   <= r_rd ? 2'b11 : r_wstrb[3:2];
            end else begin
              r_state    <= DONE;
              r_s_valid  <= 1'b0;
              r_s_we     <= 1'b0;
              r_m0_ready <= ~r_owner;
              r_m1_ready <= r_owner;
            end
          end
        end
        HI: begin
          if (s_ready) begin
            r_rdata[31:16] <= s_rdata;
            r_state        <= DONE;
            r_s_valid      <= 1'b0;
            r_s_we         <= 1'b0;
            r_m0_ready     <= ~r_owner;
            r_m1_ready     <= r_owner;
          end
        end
        DONE: begin
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_rdata = r_rdata;
  assign m1_rdata = r_rdata;
  assign m0_ready = r_m0_ready;
  assign m1_ready = r_m1_ready;
  assign s_valid  = r_s_valid;
  assign s_we     = r_s_we;
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign s_ben    = r_s_ben;
  assign busy     = (r_state != IDLE);
  assign owner    = r_owner;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. A FAIR=1 instance talks to a halfword
// SRAM model with a programmable wait count; a FAIR=0 instance shares the
// requester inputs and sits behind an always-ready responder so its grant
// order can be compared under contention.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid, s_we, s_ready;
  logic [17:0] s_addr;
  logic [15:0] s_wdata, s_rdata;
  logic [1:0]  s_ben;
  logic        busy, owner;

  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_m0_ready, f_m1_ready, f_s_valid, f_s_we, f_busy, f_owner;
  logic [17:0] f_s_addr;
  logic [15:0] f_s_wdata;
  logic [1:0]  f_s_ben;

  always #5 clk = ~clk;

  sram_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_ben(s_ben),
    .s_rdata(s_rdata), .s_ready(s_ready), .busy(busy), .owner(owner));

  sram_arbiter #(.FAIR(1'b0)) dut_fix (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready),
    .s_valid(f_s_valid), .s_we(f_s_we), .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_ben(f_s_ben),
    .s_rdata(16'h1234), .s_ready(f_s_valid), .busy(f_busy), .owner(f_owner));

  // SRAM model: 64 halfwords, s_ready after `waits` stall cycles.
  logic [15:0] mem [64];
  int          waits = 0;
  int          wcnt  = 0;
  assign s_ready = s_valid && (wcnt == waits);
  assign s_rdata = mem[s_addr[5:0]];

  always @(posedge clk) begin
    if (s_valid && s_ready && s_we) begin
      if (s_ben[0]) mem[s_addr[5:0]][7:0]  <= s_wdata[7:0];
      if (s_ben[1]) mem[s_addr[5:0]][15:8] <= s_wdata[15:8];
    end
    if (!s_valid || s_ready) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  // Monitor on the falling edge.
  logic [17:0] log_addr [$];
  logic [15:0] log_wd   [$];
  logic [1:0]  log_ben  [$];
  logic        log_we   [$];
  bit          gnt_q    [$];
  bit          fgnt_q   [$];
  int          unstable = 0, sv_cycles = 0, m0_pulses = 0, both_rdy = 0;
  bit          pend = 0;
  logic [36:0] held;

  always @(negedge clk) begin
    if (s_valid && s_ready) begin
      log_addr.push_back(s_addr);
      log_wd.push_back(s_wdata);
      log_ben.push_back(s_ben);
      log_we.push_back(s_we);
    end
    if (pend && (!s_valid || {s_we, s_addr, s_wdata, s_ben} != held)) unstable++;
    pend = s_valid && !s_ready;
    held = {s_we, s_addr, s_wdata, s_ben};
    if (s_valid) sv_cycles++;
    if (m0_ready) begin m0_pulses++; gnt_q.push_back(1'b0); end
    if (m1_ready) gnt_q.push_back(1'b1);
    if (m0_ready && m1_ready) both_rdy++;
    if (f_m0_ready) fgnt_q.push_back(1'b0);
    if (f_m1_ready) fgnt_q.push_back(1'b1);
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rdy(input bit m, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(m ? m1_ready : m0_ready) && n < 100);
  endtask

  task automatic req(input bit m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    if (m) begin m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = st; end
    else   begin m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = st; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int n, lb, sb, ub, pb, fb;
  logic [3:0] seq, fseq;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[2*i]   = 16'(i);
      mem[2*i+1] = 16'h0100 + 16'(i);
    end
    m0_valid = 0; m1_valid = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
    do_reset();

    // Reset state
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_we", s_we, 0);
    chk("rst_readies", {m1_ready, m0_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);

    // m0 read of 0x08, address changed after grant must be ignored
    lb = log_addr.size();
    req(0, 32'h0000_0008, 32'h0, 4'b0000);
    step();
    chk("rd_lo_s_valid", s_valid, 1);
    chk("rd_lo_s_addr", s_addr, 4);
    chk("rd_lo_s_ben", s_ben, 2'b11);
    chk("rd_lo_busy", busy, 1);
    chk("rd_lo_ready_early", m0_ready, 0);
    m0_addr = 32'h0000_0100;
    wait_rdy(0, n);
    m0_valid = 0;
    chk("rd_latency", n, 2);
    chk("rd_m1_ready", m1_ready, 0);
    chk("rd_rdata", m0_rdata, 32'h0102_0002);
    chk("rd_naccess", log_addr.size() - lb, 2);
    chk("rd_addr0", log_addr[lb], 4);
    chk("rd_addr1", log_addr[lb+1], 5);
    chk("rd_we", {log_we[lb], log_we[lb+1]}, 0);
    step();
    chk("rd_ready_one_cycle", m0_ready, 0);
    chk("rd_idle_busy", busy, 0);

    // m1 HI-only write
    lb = log_addr.size();
    req(1, 32'h0000_0010, 32'hAABB_CCDD, 4'b1100);
    wait_rdy(1, n);
    m1_valid = 0;
    chk("wrhi_latency", n, 2);
    chk("wrhi_owner", owner, 1);
    chk("wrhi_naccess", log_addr.size() - lb, 1);
    chk("wrhi_addr", log_addr[lb], 9);
    chk("wrhi_wdata", log_wd[lb], 16'hAABB);
    chk("wrhi_ben", log_ben[lb], 2'b11);
    chk("wrhi_we", log_we[lb], 1);
    step();
    chk("wrhi_mem9", mem[9], 16'hAABB);
    chk("wrhi_mem8", mem[8], 16'h0004);

    // m0 LO-only write
    lb = log_addr.size();
    req(0, 32'h0000_0020, 32'h1111_2222, 4'b0011);
    wait_rdy(0, n);
    m0_valid = 0;
    chk("wrlo_latency", n, 2);
    chk("wrlo_naccess", log_addr.size() - lb, 1);
    chk("wrlo_addr", log_addr[lb], 16);
    chk("wrlo_wdata", log_wd[lb], 16'h2222);
    step();
    chk("wrlo_mem16", mem[16], 16'h2222);
    chk("wrlo_mem17", mem[17], 16'h0108);

    // Mixed byte strobes across both halves
    lb = log_addr.size();
    req(0, 32'h0000_0030, 32'h5566_7788, 4'b0110);
    wait_rdy(0, n);
    m0_valid = 0;
    chk("wrmix_latency", n, 3);
    chk("wrmix_ben", {log_ben[lb], log_ben[lb+1]}, 4'b1001);
    step();
    chk("wrmix_mem24", mem[24], 16'h770C);
    chk("wrmix_mem25", mem[25], 16'h0166);

    // Read with 5 wait cycles per half; requester drops valid after grant
    waits = 5;
    lb = log_addr.size();
    sb = sv_cycles;
    ub = unstable;
    req(0, 32'h0000_0040, 32'h0, 4'b0000);
    step();
    m0_valid = 0;
    m0_addr  = 32'h0;
    wait_rdy(0, n);
    chk("wait_latency", n + 1, 13);
    chk("wait_rdata", m0_rdata, 32'h0110_0010);
    chk("wait_sv_cycles", sv_cycles - sb, 12);
    chk("wait_unstable", unstable - ub, 0);
    chk("wait_addr1", log_addr[lb+1], 33);
    step();
    waits = 0;

    // Round-robin vs fixed priority under continuous contention
    do_reset();
    pb = gnt_q.size();
    fb = fgnt_q.size();
    req(0, 32'h0000_0008, 32'h0, 4'b0000);
    req(1, 32'h0000_000C, 32'h0, 4'b0000);
    for (int i = 0; i < 16; i++) step();
    m0_valid = 0;
    m1_valid = 0;
    step();
    chk("fair_npulses", gnt_q.size() - pb, 4);
    chk("fix_npulses", fgnt_q.size() - fb, 4);
    seq  = {gnt_q[pb], gnt_q[pb+1], gnt_q[pb+2], gnt_q[pb+3]};
    fseq = {fgnt_q[fb], fgnt_q[fb+1], fgnt_q[fb+2], fgnt_q[fb+3]};
    chk("fair_order", seq, 4'b0101);
    chk("fix_order", fseq, 4'b0000);
    chk("both_ready", both_rdy, 0);

    // Reset during HI aborts the access
    waits = 2;
    n = 0;
    req(0, 32'h0000_0008, 32'h0, 4'b0000);
    do begin step(); n++; end while (!(s_valid && s_addr[0]) && n < 50);
    chk("abort_reached_hi", {s_valid, s_addr[0]}, 2'b11);
    pb = m0_pulses;
    m0_valid = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_s_valid", s_valid, 0);
    chk("abort_busy", busy, 0);
    step();
    step();
    step();
    chk("abort_no_ready", m0_pulses - pb, 0);
    waits = 0;
    req(0, 32'h0000_0008, 32'h0, 4'b0000);
    wait_rdy(0, n);
    m0_valid = 0;
    chk("post_abort_rdata", m0_rdata, 32'h0102_0002);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
